uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter; 8N1 by default.
// Define UART_TX_FIFO_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_valid_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  output logic                          ser_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

`ifdef UART_TX_FIFO_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and occupancy
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            pend_q;
  logic            push, pop, fifo_empty;

  assign wr_ready_o   = (level_q < LvlFull);
  assign push         = wr_valid_i & wr_ready_o;
  assign fifo_empty   = (level_q == '0);
  assign fifo_level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // pend_q is a registered non-empty flag: IDLE starts a frame off it, which keeps the
  // write path one register away from the FSM start decision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
      pend_q  <= !fifo_empty;
    end
  end

  // Transmitter FSM
  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            ser_tx_q, ser_tx_d;
  logic            baud_last;

  assign baud_last = (baud_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      ser_tx_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      ser_tx_q <= ser_tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q && !fifo_empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_FIFO_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered from the next state so it changes in step with state_q.
  always_comb begin
    ser_tx_d = 1'b1;
    unique case (state_d)
      StStart:  ser_tx_d = 1'b0;
      StData:   ser_tx_d = data_d[bit_d];
`ifdef UART_TX_FIFO_PARITY_EN
      StParity: ser_tx_d = ^data_d;
`endif
      default:  ser_tx_d = 1'b1;
    endcase
  end

  assign ser_tx_o  = ser_tx_q;
  assign tx_done_o = (state_q == StStop) && baud_last;
  assign busy_o    = (state_q != StIdle) || !fifo_empty;

endmodule
